rgb_pwm_sequencer: RTL and testbench
====================================

# rgb_pwm_sequencer

Parametrised RGB/multi-channel LED driver for the board's status LED. It steps through colour combinations like the plain counter blinker, and adds per-channel PWM brightness, a breathing fade mode, hold and off modes selected from the DIP switches, and configurable channel count and output polarity. It sits directly between the board switches/clock and the LED pins.

## Interface
- `PWM_BITS`, 8: PWM resolution; period is 2^PWM_BITS clocks; FULL = 2^PWM_BITS.
- `STEP_CYCLES`, 65536: clocks per sequencer step tick (>= 1).
- `CHANNELS`, 3: LED channels; bit 0 = red, 1 = green, 2 = blue.
- `ACTIVE_LOW`, 1: 1 = output 0 lights the LED.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  mode select from switches; asynchronous to `clk`.
- `led`  out  CHANNELS  registered LED drives.

## Operation
- `mode` passes through a 2-flop synchroniser; `mode_s` is the synchronised value. Modes: 0 COLOR, 1 BREATHE, 2 HOLD, 3 OFF.
- `pwm_cnt`: PWM_BITS-bit counter; increments every clock and wraps from 2^PWM_BITS-1 to 0.
- Prescaler `pre`:
  - Counts 0..STEP_CYCLES-1.
  - `tick` = (pre == STEP_CYCLES-1); `pre` returns to 0 in the same cycle.
- `color`: CHANNELS-bit colour index, wraps at 2^CHANNELS.
- `level`: PWM_BITS+1 bits, range 0..FULL.
- `dir`: 0 = up, 1 = down.
- On `tick`, by mode:
  - COLOR: `color` <= `color`+1.
  - BREATHE, `dir`=0: `level` <= `level`+1. If `level`+1 == FULL, `dir` <= 1.
  - BREATHE, `dir`=1: `level` <= `level`-1. If `level`-1 == 0, `dir` <= 0 and `color` <= `color`+1.
  - HOLD, OFF: `color`, `level` and `dir` unchanged.
- Target duty `tgt[ch]`:
  - COLOR: `color[ch]` ? FULL : 0.
  - BREATHE: `color[ch]` ? `level` : 0.
  - HOLD: the current `duty[ch]`.
  - OFF: 0.
- `duty[ch]` (PWM_BITS+1 bits) loads `tgt[ch]` only in the cycle where `pwm_cnt` == 2^PWM_BITS-1. New duties therefore start at a period boundary and never glitch mid-period.
- Channel lit iff `pwm_cnt` < `duty[ch]`:
  - duty 0 = never lit; FULL = always lit.
  - Lit cycles per period = `duty`.
- `led[ch]` <= lit XOR ACTIVE_LOW, registered.
- Mode change (`mode_s` differs from its previous registered value), in that cycle:
  - `pre` <= 0, `level` <= 0, `dir` <= 0.
  - `color` is kept; `pwm_cnt` keeps running.
  - Change has priority over a coincident `tick`, which is dropped.
- Arithmetic is unsigned. `color` wraps silently. `level` never leaves 0..FULL.

## Timing
- Reset values:
  - `pwm_cnt`=0, `pre`=0, `color`=0, `level`=0, `dir`=0, all `duty`=0.
  - Synchroniser flops = 0, i.e. COLOR.
  - `led` = all ACTIVE_LOW, i.e. dark.
- Reset asserted mid-operation returns everything to the reset values at the next edge. No partial state survives.
- Switch latency: a `mode` change affects state 2 clocks after the change (synchroniser). It affects `led` no later than the next period boundary plus 1 clock.
- Output latency: `led` at cycle t+1 reflects `pwm_cnt` and `duty` at cycle t.
- `tick` rate: one per STEP_CYCLES clocks. With STEP_CYCLES=1, `tick` is asserted every cycle.
- A `tick` coinciding with a period boundary updates `color`/`level` in that cycle. `tgt` sampled at that same boundary uses the pre-tick values; the new values apply at the following boundary.

## Test plan
All scenarios use PWM_BITS=2 (FULL=4, period 4), STEP_CYCLES=4, CHANNELS=3, ACTIVE_LOW=1.
- Reset: hold `rst` 3 cycles, release -> `led`=3'b111, and stays 3'b111 for the first full period (`duty`=0).
- COLOR stepping: `mode`=0 from reset -> `color` sequence 0,1,2,...,7,0, one step every 4 clocks. With `color`=1, in steady state `led`=3'b110 constantly (red full on).
- BREATHE ramp: `mode`=1, `color`=1 -> red low cycles per period follow `level` 0,1,2,3,4,3,2,1,0. `color` becomes 2 when `level` returns to 0. Green/blue stay 1.
- HOLD freeze: switch to `mode`=2 mid-breath at `level`=2 -> red lit exactly 2 of every 4 cycles indefinitely. `color` is unchanged after 100 clocks.
- OFF and resume: `mode`=3 -> `led`=3'b111 from the next period boundary +1 clock. Return to 1 -> `level` restarts at 0, `dir` up, `color` preserved.
- Mode-change priority: change `mode` so the synchronised edge coincides with `tick` -> no `color`/`level` step that cycle, and `pre`=0 on the next cycle.

Source files
------------

// File: rtl/rgb_pwm_sequencer.sv
// Status-LED driver: steps through channel colour combinations with per-channel
// PWM brightness, a breathing fade, and hold/off modes picked from the switches.
module rgb_pwm_sequencer #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 65536,
  parameter int unsigned CHANNELS    = 3,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led
);

  localparam int unsigned LVL_W = PWM_BITS + 1;
  localparam int unsigned PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [LVL_W-1:0]    FULL    = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [LVL_W-1:0]    LVL_ONE = LVL_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(STEP_CYCLES - 1);

  localparam logic [1:0] MODE_COLOR   = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_HOLD    = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  logic [1:0]                          mode_m;
  logic [1:0]                          mode_s;
  logic [1:0]                          mode_q;
  logic [PWM_BITS-1:0]                 pwm_cnt;
  logic [PRE_W-1:0]                    pre;
  logic [CHANNELS-1:0]                 color;
  logic [LVL_W-1:0]                    level;
  logic                                dir;
  logic [CHANNELS-1:0][LVL_W-1:0]      duty;

  logic                                tick;
  logic                                change;
  logic                                boundary;
  logic [PRE_W-1:0]                    pre_nxt;
  logic [CHANNELS-1:0]                 color_nxt;
  logic [LVL_W-1:0]                    level_nxt;
  logic                                dir_nxt;
  logic [CHANNELS-1:0][LVL_W-1:0]      tgt;
  logic [CHANNELS-1:0]                 lit;

  assign tick     = (pre == PRE_MAX);
  assign change   = (mode_s != mode_q);
  assign boundary = (pwm_cnt == CNT_MAX);

  // Sequencer next state; a mode change wins over a coincident tick.
  always_comb begin
    pre_nxt   = PRE_W'(pre + 1'b1);
    color_nxt = color;
    level_nxt = level;
    dir_nxt   = dir;
    if (change) begin
      pre_nxt   = '0;
      level_nxt = '0;
      dir_nxt   = 1'b0;
    end else if (tick) begin
      pre_nxt = '0;
      case (mode_s)
        MODE_COLOR: color_nxt = CHANNELS'(color + 1'b1);
        MODE_BREATHE: begin
          if (!dir) begin
            level_nxt = LVL_W'(level + 1'b1);
            if (level == FULL - LVL_ONE) dir_nxt = 1'b1;
          end else begin
            level_nxt = LVL_W'(level - 1'b1);
            if (level == LVL_ONE) begin
              dir_nxt   = 1'b0;
              color_nxt = CHANNELS'(color + 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel target duty and PWM compare.
  always_comb begin
    tgt = '0;
    lit = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      case (mode_s)
        MODE_COLOR:   tgt[ch] = color[ch] ? FULL : '0;
        MODE_BREATHE: tgt[ch] = color[ch] ? level : '0;
        MODE_HOLD:    tgt[ch] = duty[ch];
        MODE_OFF:     tgt[ch] = '0;
        default:      tgt[ch] = '0;
      endcase
      lit[ch] = ({1'b0, pwm_cnt} < duty[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_m  <= MODE_COLOR;
      mode_s  <= MODE_COLOR;
      mode_q  <= MODE_COLOR;
      pwm_cnt <= '0;
      pre     <= '0;
      color   <= '0;
      level   <= '0;
      dir     <= 1'b0;
      duty    <= '0;
      led     <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      mode_m  <= mode;
      mode_s  <= mode_m;
      mode_q  <= mode_s;
      pwm_cnt <= PWM_BITS'(pwm_cnt + 1'b1);
      pre     <= pre_nxt;
      color   <= color_nxt;
      level   <= level_nxt;
      dir     <= dir_nxt;
      // Duties only move at the period boundary so a period never glitches.
      if (boundary) duty <= tgt;
      led     <= lit ^ {CHANNELS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with PWM_BITS=2, STEP_CYCLES=4, CHANNELS=3,
// active-low outputs; expected LED patterns are worked out by hand per 4-cycle period.
module tb_rgb_pwm_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] led;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [1:0]      mode;
    int unsigned     reps;
    logic [0:3][2:0] exp;
  } vec_t;

  localparam int unsigned N_TBL = 26;
  vec_t tbl [N_TBL];

  rgb_pwm_sequencer #(
    .PWM_BITS   (2),
    .STEP_CYCLES(4),
    .CHANNELS   (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] m, input int unsigned r,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] d);
    vec_t v;
    v.mode = m;
    v.reps = r;
    v.exp  = {a, b, c, d};
    return v;
  endfunction

  // One clock, then compare led half a cycle later.
  task automatic step_check(input string name, input logic [2:0] exp);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (led !== exp) begin
      n_bad++;
      $display("FAIL %s: led=%b expected %b at %0t", name, led, exp, $time);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    mode  = 2'd0;

    // Each entry: mode driven one edge after a period start, then 4 checked edges.
    tbl[0]  = mk(2'd0, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[1]  = mk(2'd0, 1, 3'b111, 3'b111, 3'b111, 3'b110);
    tbl[2]  = mk(2'd0, 1, 3'b110, 3'b110, 3'b110, 3'b101);
    tbl[3]  = mk(2'd0, 1, 3'b101, 3'b101, 3'b101, 3'b100);
    tbl[4]  = mk(2'd0, 1, 3'b100, 3'b100, 3'b100, 3'b011);
    tbl[5]  = mk(2'd0, 1, 3'b011, 3'b011, 3'b011, 3'b010);
    tbl[6]  = mk(2'd0, 1, 3'b010, 3'b010, 3'b010, 3'b001);
    tbl[7]  = mk(2'd0, 1, 3'b001, 3'b001, 3'b001, 3'b000);
    tbl[8]  = mk(2'd0, 1, 3'b000, 3'b000, 3'b000, 3'b111);
    tbl[9]  = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[10] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[11] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b110);
    tbl[12] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b110);
    tbl[13] = mk(2'd1, 1, 3'b110, 3'b111, 3'b111, 3'b110);
    tbl[14] = mk(2'd1, 1, 3'b110, 3'b110, 3'b111, 3'b110);
    tbl[15] = mk(2'd1, 1, 3'b110, 3'b110, 3'b110, 3'b110);
    tbl[16] = mk(2'd1, 1, 3'b110, 3'b110, 3'b111, 3'b110);
    tbl[17] = mk(2'd2, 1, 3'b110, 3'b111, 3'b111, 3'b110);
    tbl[18] = mk(2'd2, 26, 3'b110, 3'b111, 3'b111, 3'b110);
    tbl[19] = mk(2'd3, 1, 3'b110, 3'b111, 3'b111, 3'b111);
    tbl[20] = mk(2'd3, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[21] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[22] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b111);
    tbl[23] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b110);
    tbl[24] = mk(2'd1, 1, 3'b111, 3'b111, 3'b111, 3'b110);
    tbl[25] = mk(2'd1, 1, 3'b110, 3'b111, 3'b111, 3'b110);

    for (int i = 0; i < 3; i++) step_check("reset_hold", 3'b111);
    rst = 1'b0;
    step_check("first_edge", 3'b111);

    for (int k = 0; k < int'(N_TBL); k++) begin
      mode = tbl[k].mode;
      for (int r = 0; r < int'(tbl[k].reps); r++) begin
        for (int i = 0; i < 4; i++) begin
          step_check($sformatf("vec%0d_rep%0d_cyc%0d", k, r, i), tbl[k].exp[i]);
        end
      end
    end

    // Reset in the middle of breathing must clear every piece of state.
    rst  = 1'b1;
    mode = 2'd1;
    step_check("midrun_reset0", 3'b111);
    step_check("midrun_reset1", 3'b111);
    rst  = 1'b0;
    mode = 2'd0;
    step_check("post_reset_c1", 3'b111);

    // Mode change away from a tick edge: prescaler restarts, shifting colour steps.
    mode = 2'd2;
    for (int i = 2; i <= 4; i++) step_check($sformatf("realign_c%0d", i), 3'b111);
    mode = 2'd0;
    for (int i = 5; i <= 12; i++) step_check($sformatf("realign_c%0d", i), 3'b111);
    for (int i = 13; i <= 16; i++) step_check($sformatf("realign_c%0d", i), 3'b110);
    for (int i = 17; i <= 20; i++) step_check($sformatf("realign_c%0d", i), 3'b101);
    for (int i = 21; i <= 24; i++) step_check($sformatf("realign_c%0d", i), 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
